// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the SM83 memory-bus controller: regions, FSM states and
// address-window constants.
package mem_map_pkg;

  typedef enum logic [1:0] {
    RegionRom,
    RegionWram,
    RegionReg,
    RegionUnmapped
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StWrite
  } state_e;

  typedef enum logic {
    GrantCpu,
    GrantDma
  } grant_e;

  localparam logic [15:0] RomLimit    = 16'h00FF;
  localparam logic [15:0] WramBase    = 16'hC000;
  localparam logic [15:0] WramLimit   = 16'hDFFF;
  localparam logic [15:0] EchoBase    = 16'hE000;
  localparam logic [15:0] EchoLimit   = 16'hFDFF;
  localparam logic [15:0] BootDisAddr = 16'hFF50;

  function automatic logic in_range(logic [15:0] addr, logic [15:0] lo, logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder: maps a 16-bit bus address and the overlay flag onto a target
// region plus the local bootrom / work_ram addresses.
module mem_addr_decode
  import mem_map_pkg::*;
#(
  parameter int unsigned ROM_AW        = 8,
  parameter int unsigned WRAM_AW       = 13,
  parameter logic [15:0] BOOT_DIS_ADDR = BootDisAddr
) (
  input  logic [15:0]        addr,
  input  logic               boot_en,
  output region_e            region,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [WRAM_AW-1:0] wram_addr
);

  always_comb begin
    region = RegionUnmapped;
    if (boot_en && (addr <= RomLimit)) begin
      region = RegionRom;
    end else if (in_range(addr, WramBase, WramLimit) || in_range(addr, EchoBase, EchoLimit)) begin
      // Echo window aliases work_ram through the same low address bits.
      region = RegionWram;
    end else if (addr == BOOT_DIS_ADDR) begin
      region = RegionReg;
    end
  end

  assign rom_addr  = addr[ROM_AW-1:0];
  assign wram_addr = addr[WRAM_AW-1:0];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: round-robin CPU/DMA arbitration, address decode onto bootrom/work_ram,
// synchronous-read latency hiding behind req/ready, and the boot-ROM overlay disable register.
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned ROM_AW        = 8,
  parameter int unsigned WRAM_AW       = 13,
  parameter logic [15:0] BOOT_DIS_ADDR = BootDisAddr,
  parameter logic [7:0]  OPEN_BUS      = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ready,
  input  logic               dma_req,
  input  logic [15:0]        dma_addr,
  output logic [7:0]         dma_rdata,
  output logic               dma_valid,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [7:0]         rom_dout,
  output logic [WRAM_AW-1:0] wram_addr,
  output logic               wram_we,
  output logic [7:0]         wram_din,
  input  logic [7:0]         wram_dout,
  output logic               boot_en
);

  state_e  state_q;
  grant_e  last_grant_q;
  grant_e  owner_q;
  region_e target_q;

  logic               cpu_act;
  grant_e             grant;
  logic [15:0]        grant_addr;
  region_e            dec_region;
  logic [ROM_AW-1:0]  dec_rom_addr;
  logic [WRAM_AW-1:0] dec_wram_addr;
  logic [7:0]         rd_data;

  // A lone requester always wins; on contention the one not granted last time wins.
  always_comb begin
    cpu_act = cpu_rd | cpu_wr;
    if (dma_req && (!cpu_act || (last_grant_q == GrantCpu))) begin
      grant = GrantDma;
    end else begin
      grant = GrantCpu;
    end
    grant_addr = (grant == GrantDma) ? dma_addr : cpu_addr;
  end

  mem_addr_decode #(
    .ROM_AW       (ROM_AW),
    .WRAM_AW      (WRAM_AW),
    .BOOT_DIS_ADDR(BOOT_DIS_ADDR)
  ) u_decode (
    .addr     (grant_addr),
    .boot_en  (boot_en),
    .region   (dec_region),
    .rom_addr (dec_rom_addr),
    .wram_addr(dec_wram_addr)
  );

  always_comb begin
    rd_data = OPEN_BUS;
    case (target_q)
      RegionRom:  rd_data = rom_dout;
      RegionWram: rd_data = wram_dout;
      default:    rd_data = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantDma;
      owner_q      <= GrantCpu;
      target_q     <= RegionUnmapped;
      cpu_ready    <= 1'b0;
      dma_valid    <= 1'b0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      rom_addr     <= '0;
      wram_addr    <= '0;
      wram_we      <= 1'b0;
      wram_din     <= '0;
      boot_en      <= 1'b1;
    end else begin
      cpu_ready <= 1'b0;
      dma_valid <= 1'b0;
      wram_we   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_act || dma_req) begin
            last_grant_q <= grant;
            owner_q      <= grant;
            target_q     <= dec_region;
            if (dec_region == RegionRom) begin
              rom_addr <= dec_rom_addr;
            end
            if (dec_region == RegionWram) begin
              wram_addr <= dec_wram_addr;
            end
            if ((grant == GrantCpu) && cpu_wr) begin
              if (dec_region == RegionWram) begin
                wram_we  <= 1'b1;
                wram_din <= cpu_wdata;
              end
              // Overlay disable is sticky; only a non-zero write clears it.
              if ((dec_region == RegionReg) && (cpu_wdata != 8'h00)) begin
                boot_en <= 1'b0;
              end
              state_q <= StWrite;
            end else begin
              state_q <= StAddr;
            end
          end
        end
        StAddr: begin
          state_q <= StData;
        end
        StData: begin
          if (owner_q == GrantDma) begin
            dma_rdata <= rd_data;
            dma_valid <= 1'b1;
          end else begin
            cpu_rdata <= rd_data;
            cpu_ready <= 1'b1;
          end
          state_q <= StIdle;
        end
        StWrite: begin
          cpu_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory-bus controller between the SM83 core, a DMA requester, the bootrom and work_ram block memories. It decodes 16-bit addresses onto the on-chip memories and arbitrates CPU and DMA access with round-robin. It absorbs the one-cycle synchronous-read latency of the block RAMs behind a req/ready handshake. It owns the boot-ROM overlay disable register at 0xFF50.

Parameters:
ROM_AW, 8, bootrom address width (256 B overlay at 0x0000-0x00FF)
WRAM_AW, 13, work_ram address width (8 KiB)
BOOT_DIS_ADDR, 16'hFF50, boot-ROM disable register address
OPEN_BUS, 8'hFF, read data returned for unmapped addresses

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
cpu_addr  in  16  CPU address
cpu_rd  in  1  CPU read request, held until cpu_ready
cpu_wr  in  1  CPU write request, held until cpu_ready
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data, valid when cpu_ready=1, then held
cpu_ready  out  1  one-cycle completion pulse to the CPU
dma_req  in  1  DMA read request, held until dma_valid
dma_addr  in  16  DMA source address
dma_rdata  out  8  DMA read data, valid when dma_valid=1
dma_valid  out  1  one-cycle completion pulse to DMA
rom_addr  out  ROM_AW  bootrom address
rom_dout  in  8  bootrom data, one cycle after rom_addr
wram_addr  out  WRAM_AW  work_ram address
wram_we  out  1  work_ram write enable
wram_din  out  8  work_ram write data
wram_dout  in  8  work_ram data, one cycle after wram_addr
boot_en  out  1  1 = bootrom overlay active

Behaviour:
- Reset (rst=0, async). State=IDLE; cpu_ready=0, dma_valid=0, wram_we=0; cpu_rdata=0, dma_rdata=0; rom_addr=0, wram_addr=0, wram_din=0; boot_en=1; last_grant=DMA. Any in-flight transfer is discarded with no ready/valid pulse. wram_we drops immediately.
- Address decode:
  - 0x0000-0x00FF with boot_en=1 → ROM.
  - 0xC000-0xDFFF → WRAM at addr[12:0].
  - 0xE000-0xFDFF → WRAM echo at addr[12:0].
  - BOOT_DIS_ADDR → REG.
  - Everything else, including 0x0000-0x00FF with boot_en=0 → UNMAPPED.
- Request priority: in IDLE, cpu_wr wins over cpu_rd if both are high.
- Arbitration (IDLE only). If exactly one requester is active, grant it. If both are active, grant the one not in last_grant, then update last_grant. Requests are sampled only in IDLE. A requester dropping its request before completion is illegal; the transaction completes anyway.
- FSM states: IDLE, ADDR, DATA, WRITE.
  - IDLE→ADDR on a read grant: register the decoded memory address and latch requester and target.
  - ADDR→DATA: memory samples the address at this edge.
  - DATA→IDLE: capture into the requester's rdata (rom_dout, wram_dout, or OPEN_BUS for UNMAPPED/REG). Assert ready/valid for exactly one cycle.
  - Read latency: grant edge E0 → pulse high in the cycle after E0+2 (3 cycles from request sample).
  - IDLE→WRITE on a CPU write grant: wram_we=1 for one cycle if the target is WRAM, with wram_din=cpu_wdata. If the target is REG and cpu_wdata≠0, clear boot_en. Writes to ROM or UNMAPPED are ignored.
  - WRITE→IDLE: cpu_ready pulses in the cycle after E0+1.
- boot_en is sticky 0 until reset. A write of 0 leaves it unchanged. The cycle after it clears, 0x0000-0x00FF reads return OPEN_BUS.
- Back-to-back: IDLE re-arbitrates in the cycle the pulse is high. A requester must deassert or present a new request in that cycle; a held request is treated as a new transaction.
- wram_addr and rom_addr hold their last value when idle. The rdata registers hold until that requester's next read completes.

Decomposition:
- Shared package mem_map_pkg:
  - region enum (ROM, WRAM, REG, UNMAPPED);
  - FSM state encoding;
  - base/limit constants 0x00FF, 0xC000, 0xDFFF, 0xE000, 0xFDFF, 0xFF50.
- Sub-module mem_addr_decode: combinational 16-bit addr + boot_en → region + local address. It is instantiated once, on the muxed granted address.

Test Plan:
- Reset, then CPU read 0x0005 with bootrom[5]=0x3E → cpu_ready after 3 cycles, cpu_rdata=0x3E; boot_en=1.
- CPU write 0xC123=0xA5, then read 0xE123 → wram_we is a single pulse at addr 0x0123, and the echo read returns 0xA5.
- CPU write 0xFF50=0x01, then read 0x0005 → boot_en=0, cpu_rdata=0xFF. A prior write of 0x00 to 0xFF50 left boot_en=1.
- cpu_rd 0xC000 and dma_req 0xC001 held continuously for 4 transactions → grants alternate DMA, CPU, DMA, CPU. Each requester receives its correct data, and there is never a simultaneous ready+valid.
- rst pulled low during DATA of a DMA read → dma_valid never pulses, all outputs reset at once. The first transaction after release completes normally.
- Read 0x8000 (unmapped) and write 0x9000 → read returns 0xFF, write produces no wram_we. Both complete with a cpu_ready pulse.
